// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer:
// FSM state encoding, the two memory opcodes and the load/store funct3 codes.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } mem_state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Bit 2 of funct3 marks the unsigned load variants; stores never set it.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: replicates store data across lanes,
// builds big-endian byte enables, checks alignment and picks the load shift.
module mem_lane_steer
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic        aligned,
    output logic [4:0]  load_shift
);

    // Byte offset 0 lives in lane 3, so masks shift right as the offset grows.
    always_comb begin
        wdata      = store_data;
        wmask      = 4'b0000;
        aligned    = 1'b0;
        load_shift = {byte_off, 3'b000};
        case (funct3)
            F3_B, F3_BU: begin
                wdata   = {4{store_data[7:0]}};
                wmask   = 4'b1000 >> byte_off;
                aligned = 1'b1;
            end
            F3_H, F3_HU: begin
                wdata   = {2{store_data[15:0]}};
                wmask   = (byte_off == 2'b00) ? 4'b1100 : 4'b0011;
                aligned = ~byte_off[0];
            end
            F3_W: begin
                wdata   = store_data;
                wmask   = 4'b1111;
                aligned = (byte_off == 2'b00);
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute and the shared data-memory port:
// runs one req/ack bus transaction per access, stalls execute, and times out.
module mem_access_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [11:0]     operation,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic            done,
    output logic            fault,
    output logic [31:0]     memData,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata
);

    import mem_ctrl_pkg::*;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

    mem_state_t        state;
    mem_state_t        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [4:0]        shift_q;
    logic [31:0]       mem_data_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        start;
    logic        legal;
    logic        accept;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic        lane_aligned;
    logic [4:0]  lane_shift;
    logic        enter_busy;
    logic        leave_busy;
    logic        unused_op_bits;

    assign opcode         = operation[6:0];
    assign funct3         = operation[9:7];
    assign unused_op_bits = ^operation[11:10];
    assign is_load        = (opcode == OP_LOAD);
    assign is_store       = (opcode == OP_STORE);
    assign start          = valid & (is_load | is_store);

    mem_lane_steer u_steer (
        .funct3     (funct3),
        .byte_off   (addr[1:0]),
        .store_data (store_data[31:0]),
        .wdata      (lane_wdata),
        .wmask      (lane_wmask),
        .aligned    (lane_aligned),
        .load_shift (lane_shift)
    );

    // Unsigned funct3 codes only exist for loads, so a store using one is illegal.
    assign legal  = lane_aligned & (is_load | ~funct3[2]);
    assign accept = start & legal;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = legal ? ST_BUSY : ST_FAULT;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    next_state = ST_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ST_FAULT;
                end
            end
            ST_DONE: begin
                next_state = accept ? ST_BUSY : ST_IDLE;
            end
            ST_FAULT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign stall = (state == ST_BUSY) |
                   (((state == ST_IDLE) | (state == ST_DONE)) & accept);
    assign done    = (state == ST_DONE);
    assign fault   = (state == ST_FAULT);
    assign memData = mem_data_q;

    assign enter_busy = (state != ST_BUSY) & (next_state == ST_BUSY);
    assign leave_busy = (state == ST_BUSY) & (next_state != ST_BUSY);

    // Bus outputs are loaded on entry to BUSY and cleared on exit, so they are
    // glitch-free registers and the write strobes are quiet whenever req is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            shift_q    <= '0;
            mem_data_q <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wmask  <= 4'b0000;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            state <= next_state;
            if (enter_busy) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_wmask <= lane_wmask;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= lane_wdata;
                shift_q   <= lane_shift;
                wait_cnt  <= '0;
            end else if (leave_busy) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_wmask <= 4'b0000;
            end else if ((state == ST_BUSY) && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == ST_BUSY) && mem_ack && !mem_we) begin
                mem_data_q <= mem_rdata << shift_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a table of single accesses run
// through a scoreboard, plus hand-written reset and back-to-back sequences.
module tb_mem_access_ctrl;

    localparam int TIMEOUT_P = 4;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;
    localparam int K_OK  = 0;
    localparam int K_MIS = 1;
    localparam int K_TMO = 2;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        bit          st;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          delay;
        int          kind;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [11:0] operation;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] memData;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int   vec_count  = 0;
    int   miscompares = 0;
    vec_t vectors[$];
    vec_t exp_q[$];

    mem_access_ctrl #(.XLEN(32), .TIMEOUT(TIMEOUT_P)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .operation  (operation),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .memData    (memData),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Pops the oldest expected access and checks the completion cycle against it.
    task automatic scoreboardCheck(input int cyc);
        vec_t v;
        int   exp_cyc;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        v = exp_q.pop_front();
        exp_cyc = (v.kind == K_OK) ? v.delay + 1 : (v.kind == K_TMO) ? TIMEOUT_P : 0;
        checkOutput({v.name, "_latency"}, 32'(cyc), 32'(exp_cyc));
        checkOutput({v.name, "_done"}, {31'd0, done}, {31'd0, v.kind == K_OK});
        checkOutput({v.name, "_fault"}, {31'd0, fault}, {31'd0, v.kind != K_OK});
        checkOutput({v.name, "_req_end"}, {31'd0, mem_req}, 32'd0);
        checkOutput({v.name, "_stall_end"}, {31'd0, stall}, 32'd0);
        if (v.kind == K_OK && !v.st) begin
            checkOutput({v.name, "_memData"}, memData, v.exp_data);
        end
    endtask

    // Entered and left just after a rising edge with the FSM idle.
    task automatic applyStimulus(input vec_t v);
        bit got;
        valid      = 1'b1;
        operation  = {2'b00, v.f3, v.st ? OPC_STORE : OPC_LOAD};
        addr       = v.addr;
        store_data = v.sd;
        exp_q.push_back(v);
        @(negedge clk);
        checkOutput({v.name, "_stall_start"}, {31'd0, stall}, {31'd0, v.kind != K_MIS});
        @(posedge clk); #1;
        valid     = 1'b0;
        operation = '0;
        if (v.kind == K_MIS) begin
            @(negedge clk);
            scoreboardCheck(0);
            @(posedge clk); #1;
            return;
        end
        got = 1'b0;
        for (int c = 0; c <= TIMEOUT_P + 1; c++) begin
            mem_ack   = (c == v.delay);
            mem_rdata = (c == v.delay) ? v.rdata : 32'h0BAD0BAD;
            @(negedge clk);
            if (done || fault) begin
                scoreboardCheck(c);
                got = 1'b1;
            end else begin
                checkOutput({v.name, "_req"}, {31'd0, mem_req}, 32'd1);
                checkOutput({v.name, "_stall_busy"}, {31'd0, stall}, 32'd1);
                if (c == 0) begin
                    checkOutput({v.name, "_addr"}, mem_addr, {v.addr[31:2], 2'b00});
                    checkOutput({v.name, "_we"}, {31'd0, mem_we}, {31'd0, v.st});
                    if (v.st) begin
                        checkOutput({v.name, "_wdata"}, mem_wdata, v.exp_wdata);
                        checkOutput({v.name, "_wmask"}, {28'd0, mem_wmask}, {28'd0, v.exp_mask});
                    end
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (got) break;
        end
        if (!got) begin
            checkOutput({v.name, "_completion"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        checkOutput({v.name, "_idle_after"}, {30'd0, done, fault}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset      = 1'b1;
        valid      = 1'b0;
        operation  = '0;
        addr       = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        vectors.push_back('{"lw_imm",     3'b010, 0, 32'h100,  32'h0,        32'hDEADBEEF, 0,   K_OK,  32'h0,        4'b0000, 32'hDEADBEEF});
        vectors.push_back('{"sb_lane",    3'b000, 1, 32'h103,  32'h000000A5, 32'h0,        1,   K_OK,  32'hA5A5A5A5, 4'b0001, 32'h0});
        vectors.push_back('{"lh_delay",   3'b001, 0, 32'h202,  32'h0,        32'h1122BEEF, 3,   K_OK,  32'h0,        4'b0000, 32'hBEEF0000});
        vectors.push_back('{"lw_misal",   3'b010, 0, 32'h101,  32'h0,        32'h0,        0,   K_MIS, 32'h0,        4'b0000, 32'h0});
        vectors.push_back('{"sh_k2",      3'b001, 1, 32'h102,  32'h1234ABCD, 32'h0,        2,   K_OK,  32'hABCDABCD, 4'b0011, 32'h0});
        vectors.push_back('{"sh_k0",      3'b001, 1, 32'h200,  32'hFFFF5678, 32'h0,        0,   K_OK,  32'h56785678, 4'b1100, 32'h0});
        vectors.push_back('{"lbu_k1",     3'b100, 0, 32'h301,  32'h0,        32'h11223344, 1,   K_OK,  32'h0,        4'b0000, 32'h22334400});
        vectors.push_back('{"lb_k2",      3'b000, 0, 32'h302,  32'h0,        32'hAABBCCDD, 2,   K_OK,  32'h0,        4'b0000, 32'hCCDD0000});
        vectors.push_back('{"lb_k3",      3'b000, 0, 32'h8003, 32'h0,        32'h99AABBCC, 0,   K_OK,  32'h0,        4'b0000, 32'hCC000000});
        vectors.push_back('{"sh_misal",   3'b001, 1, 32'h101,  32'h0,        32'h0,        0,   K_MIS, 32'h0,        4'b0000, 32'h0});
        vectors.push_back('{"sw",         3'b010, 1, 32'h40C,  32'hCAFEF00D, 32'h0,        0,   K_OK,  32'hCAFEF00D, 4'b1111, 32'h0});
        vectors.push_back('{"lhu_k2",     3'b101, 0, 32'h2,    32'h0,        32'h55667788, 1,   K_OK,  32'h0,        4'b0000, 32'h77880000});
        vectors.push_back('{"ld_bad_f3",  3'b011, 0, 32'h0,    32'h0,        32'h0,        0,   K_MIS, 32'h0,        4'b0000, 32'h0});
        vectors.push_back('{"st_bad_f3",  3'b100, 1, 32'h0,    32'h0,        32'h0,        0,   K_MIS, 32'h0,        4'b0000, 32'h0});
        vectors.push_back('{"sb_k0",      3'b000, 1, 32'h100,  32'h00000012, 32'h0,        0,   K_OK,  32'h12121212, 4'b1000, 32'h0});
        vectors.push_back('{"lw_timeout", 3'b010, 0, 32'h500,  32'h0,        32'h0,        255, K_TMO, 32'h0,        4'b0000, 32'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req",   {31'd0, mem_req}, 32'd0);
        checkOutput("rst_flags", {29'd0, done, fault, stall}, 32'd0);
        checkOutput("rst_we_mask", {27'd0, mem_we, mem_wmask}, 32'd0);
        checkOutput("rst_memData", memData, 32'h0);
        checkOutput("rst_addr",  mem_addr, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i]);
        end

        // Non-memory opcode and a stray ack in IDLE must both be ignored.
        valid     = 1'b1;
        operation = {2'b00, 3'b000, OPC_ALU};
        mem_ack   = 1'b1;
        @(negedge clk);
        checkOutput("alu_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        valid   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("alu_quiet", {29'd0, mem_req, done, fault}, 32'd0);
        @(posedge clk); #1;

        // Reset while BUSY drops the request without waiting for a clock edge.
        valid      = 1'b1;
        operation  = {2'b00, 3'b010, OPC_LOAD};
        addr       = 32'h600;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        checkOutput("rmid_req_before", {31'd0, mem_req}, 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rmid_req_async", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rmid_no_pulse", {28'd0, mem_req, done, fault, stall}, 32'd0);
            @(posedge clk); #1;
        end

        // Back-to-back stores: the second start lands in the DONE cycle.
        valid      = 1'b1;
        operation  = {2'b00, 3'b010, OPC_STORE};
        addr       = 32'h700;
        store_data = 32'h11111111;
        @(posedge clk); #1;
        valid   = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("b2b_req1", {31'd0, mem_req}, 32'd1);
        checkOutput("b2b_wdata1", mem_wdata, 32'h11111111);
        @(posedge clk); #1;
        mem_ack    = 1'b0;
        valid      = 1'b1;
        addr       = 32'h704;
        store_data = 32'h22222222;
        @(negedge clk);
        checkOutput("b2b_done1", {31'd0, done}, 32'd1);
        checkOutput("b2b_req_gap", {31'd0, mem_req}, 32'd0);
        checkOutput("b2b_stall_done", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_req2", {31'd0, mem_req}, 32'd1);
        checkOutput("b2b_addr2", mem_addr, 32'h704);
        checkOutput("b2b_wdata2", mem_wdata, 32'h22222222);
        checkOutput("b2b_we2", {31'd0, mem_we}, 32'd1);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("b2b_done2", {30'd0, done, mem_req}, 32'd2);
        @(posedge clk); #1;

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the execute stage and the shared data-memory port. It accepts one load or store per request from execute, runs a request/acknowledge transaction on the word-wide memory bus, and stalls the pipeline until the access completes. It also handles byte-lane steering, alignment checking and a bus timeout. Load data is returned left-justified on `memData`, so bits [31:24] hold a byte and [31:16] hold a halfword, ready for execute's load extension.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.
- `TIMEOUT`, 64: maximum number of cycles spent waiting for `mem_ack`. Legal range is 2..255.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `valid`  in  1: execute stage presents an instruction this cycle.
- `operation`  in  12: funct concatenated with opcode. [9:7] is funct3 and [6:0] is opcode.
- `addr`  in  XLEN: effective address, taken from the ALU result.
- `store_data`  in  XLEN: rs2 value after forwarding.
- `stall`  out  1: freezes the pipeline while an access is in flight.
- `done`  out  1: one-cycle pulse when `memData` is valid or a store has been acknowledged.
- `fault`  out  1: one-cycle pulse on a misaligned access or a timeout.
- `memData`  out  32: left-justified load data.
- `mem_req`  out  1: bus request, held until acknowledged.
- `mem_we`  out  1: 1 = write.
- `mem_addr`  out  32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32: replicated store data.
- `mem_wmask`  out  4: byte enables. Bit 3 enables [31:24], which is byte offset 0 (big-endian lanes).
- `mem_ack`  in  1: bus completes the request this cycle.
- `mem_rdata`  in  32: read word, valid while `mem_ack` is high.

## Operation
- `start = valid & (opcode==7'b0000011 | opcode==7'b0100011)`. Any other opcode is ignored.
- Loads use funct3 000 (LB), 001 (LH), 010 (LW), 100 (LBU) and 101 (LHU). Stores use funct3 000 (SB), 001 (SH) and 010 (SW). An unlisted funct3 is treated as misaligned and raises `fault`.
- Alignment rules:
  - Byte accesses are always aligned.
  - Halfword accesses require `addr[0]==0`.
  - Word accesses require `addr[1:0]==0`.
- Store lanes, with `k = addr[1:0]`:
  - SB: `wdata={4{sd[7:0]}}`, `mask=4'b1000>>k`.
  - SH: `wdata={2{sd[15:0]}}`, `mask = k==0 ? 4'b1100 : 4'b0011`.
  - SW: `wdata=sd`, `mask=4'b1111`.
- Load return: `memData = mem_rdata << (8*k)`. The value is captured in a register on the cycle `mem_ack` is high. Sign extension is not done here.
- FSM states are IDLE, BUSY, DONE and FAULT. Encodings are defined in the package.
  - IDLE: on an aligned `start`, latch the address, lanes and kind, then go to BUSY. On a misaligned `start`, go to FAULT.
  - BUSY: `mem_req=1`. If `mem_ack`, capture data and go to DONE. If the wait counter reaches TIMEOUT-1 with no ack, go to FAULT.
  - DONE: `done=1` for one cycle. An aligned `start` in this cycle goes straight to BUSY; otherwise go to IDLE.
  - FAULT: `fault=1` for one cycle, then go to IDLE. A `start` arriving in FAULT is ignored.
- `stall = (state==BUSY) | ((state==IDLE | state==DONE) & start & aligned)`. A faulting access does not stall.
- While BUSY, `valid` and `operation` are ignored. Execute holds them because it is stalled.
- `mem_ack` outside BUSY is ignored.
- All `mem_*` outputs are registered.
- `mem_wmask` is 0 and `mem_we` is 0 whenever `mem_req` is 0.

## Timing
- Reset values: state=IDLE, and `mem_req`, `mem_we`, `mem_wmask`, `done`, `fault` and the counter are all 0. `memData`, `mem_addr` and `mem_wdata` reset to 32'h0.
- Reset asserted mid-transaction drops `mem_req` immediately. No `done` or `fault` pulse is issued.
- Latency with `start` accepted at cycle T:
  - `mem_req` rises at T+1.
  - An ack at T+1+n gives `done` at T+2+n.
  - The minimum is 2 cycles from start to done.
- A timeout gives `fault` at T+1+TIMEOUT, and `mem_req` falls at that same edge.
- The wait counter is 8 bits and saturating. It clears on entry to BUSY.
- Back-to-back accesses (start in DONE) give `mem_req` low for exactly one cycle between them: the DONE cycle.

## Structure
- `mem_ctrl_pkg` contains:
  - the state enum;
  - opcode constants LOAD=7'b0000011 and STORE=7'b0100011;
  - the funct3 constants.
- A sub-module `mem_lane_steer` handles the combinational steering:
  - inputs: funct3, `addr[1:0]` and `store_data`;
  - outputs: wdata, wmask, aligned and the load shift amount.
- The FSM, counter and registers stay in `mem_access_ctrl`.

## Test plan
- **LW, immediate ack:** LW at 0x100 with `mem_ack` returned on the first `mem_req` cycle and rdata=0xDEADBEEF → `memData`=0xDEADBEEF, `done` at T+2, `stall` high during T and T+1 only.
- **SB lane steering:** SB at 0x103 with `store_data`=0x000000A5 → `mem_addr`=0x100, `mem_wdata`=0xA5A5A5A5, `mem_wmask`=4'b0001, `mem_we`=1.
- **LH with delayed ack:** LH at 0x202, ack after 3 wait cycles, rdata=0x1122BEEF → `memData`=0xBEEF0000, `done` at T+5.
- **Misaligned LW:** LW at 0x101 → no `mem_req`, `fault` at T+1, `stall` never asserted.
- **Timeout:** TIMEOUT=4 and ack never arrives → `mem_req` high for cycles T+1..T+4, `fault` at T+5, FSM back in IDLE.
- **Reset mid-access, then back-to-back:** reset asserted during BUSY → `mem_req` drops asynchronously, no `done` or `fault`. Afterwards, two back-to-back SW accesses (second start in DONE) → second `mem_req` rises exactly one cycle after the first `done`.
